// File: rtl/cmd_parser_mp.sv
// UART command parser for the md5 match engine: SET/PROC/RET/STATUS.
// Optional inter-byte receive timeout when CMD_TIMEOUT_EN is defined.
module cmd_parser_mp #(
  parameter int          NUM_LEDS       = 8,
  parameter int          HASH_BYTES     = 16,
  parameter int          LEN_BYTES      = 2,
  parameter int          MATCH_LEN      = 20,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [3:0]  VERSION        = 4'h2,
  localparam int         HW             = 8 * HASH_BYTES,
  localparam int         LW             = 8 * LEN_BYTES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rxd_data,
  input  logic                rxd_data_ready,
  input  logic                txd_busy,
  output logic                txd_start,
  output logic [7:0]          txd_data,
  input  logic                proc_done,
  input  logic                proc_match,
  input  logic [LW-1:0]       proc_byte_pos,
  input  logic [7:0]          proc_match_char,
  output logic                proc_start,
  output logic [LW-1:0]       proc_num_bytes,
  output logic [7:0]          proc_data,
  output logic                proc_data_valid,
  output logic                proc_match_char_next,
  output logic [HW-1:0]       proc_target_hash,
  output logic                cmd_error,
  output logic [NUM_LEDS-1:0] led
);

  localparam int IW = 16;

  typedef enum logic [3:0] {
    IDLE, SET_HASH, PROC_LEN, PROC_DATA, PROC_WAIT,
    RET_POS, RET_STR, STATUS, ACK, NACK
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pos_q, pos_d;
  logic [HW-1:0] shadow_q, shadow_d;
  logic [HW-1:0] hash_q, hash_d;
  logic          loaded_q, loaded_d;
  logic          last_match_q, last_match_d;
  logic          pstart_q, pstart_d;
  logic [7:0]    pdata_q, pdata_d;
  logic          pvalid_q, pvalid_d;
  logic          err_q, err_d;
  logic          start_prev_q;
  logic [7:0]    txd_data_q;
  logic [7:0]    tx_byte;
  logic          tmo_hit;
  logic          rx_state;
  logic [31:0]   led_full;

  assign rx_state = (state_q == SET_HASH) || (state_q == PROC_LEN) ||
                    (state_q == PROC_DATA);

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (rx_state && !rxd_data_ready) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                   tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      pos_q        <= '0;
      shadow_q     <= '0;
      hash_q       <= '0;
      loaded_q     <= 1'b0;
      last_match_q <= 1'b0;
      pstart_q     <= 1'b0;
      pdata_q      <= '0;
      pvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      start_prev_q <= 1'b0;
      txd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      pos_q        <= pos_d;
      shadow_q     <= shadow_d;
      hash_q       <= hash_d;
      loaded_q     <= loaded_d;
      last_match_q <= last_match_d;
      pstart_q     <= pstart_d;
      pdata_q      <= pdata_d;
      pvalid_q     <= pvalid_d;
      err_q        <= err_d;
      start_prev_q <= txd_start;
      txd_data_q   <= txd_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    pos_d        = pos_q;
    shadow_d     = shadow_q;
    hash_d       = hash_q;
    loaded_d     = loaded_q;
    last_match_d = last_match_q;
    pstart_d     = 1'b0;
    pdata_d      = pdata_q;
    pvalid_d     = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxd_data_ready) begin
          idx_d = '0;
          cnt_d = '0;
          unique case (rxd_data)
            8'h01: begin
              state_d  = SET_HASH;
              shadow_d = '0;
            end
            8'h02: state_d = PROC_LEN;
            8'h03: begin
              state_d = RET_POS;
              pos_d   = proc_byte_pos;
            end
            8'h04: state_d = STATUS;
            default: begin
              state_d = NACK;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      SET_HASH: begin
        if (tmo_hit) begin
          state_d  = NACK;
          err_d    = 1'b1;
          shadow_d = '0;
        end else if (rxd_data_ready) begin
          shadow_d = (shadow_q << 8) | HW'(rxd_data);
          idx_d    = idx_q + 1'b1;
          // commit the whole hash in one cycle, never a partial one
          if (idx_q == IW'(HASH_BYTES - 1)) begin
            hash_d   = shadow_d;
            loaded_d = 1'b1;
            state_d  = ACK;
          end
        end
      end
      PROC_LEN: begin
        if (tmo_hit) begin
          state_d = NACK;
          err_d   = 1'b1;
        end else if (rxd_data_ready) begin
          len_d = (len_q << 8) | LW'(rxd_data);
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(LEN_BYTES - 1)) begin
            if (len_d == '0) begin
              state_d = NACK;
            end else begin
              state_d  = PROC_DATA;
              pstart_d = 1'b1;
            end
          end
        end
      end
      PROC_DATA: begin
        if (tmo_hit) begin
          state_d = NACK;
          err_d   = 1'b1;
        end else if (rxd_data_ready) begin
          pdata_d  = rxd_data;
          pvalid_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == len_q - LW'(1)) state_d = PROC_WAIT;
        end
      end
      PROC_WAIT: begin
        if (proc_done) begin
          last_match_d = proc_match;
          state_d      = proc_match ? ACK : NACK;
        end
      end
      RET_POS: begin
        if (txd_start) begin
          pos_d = pos_q << 8;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(LEN_BYTES - 1)) begin
            state_d = RET_STR;
            idx_d   = '0;
          end
        end
      end
      RET_STR: begin
        if (txd_start) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(MATCH_LEN - 1)) state_d = IDLE;
        end
      end
      STATUS, ACK, NACK: begin
        if (txd_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      RET_POS: tx_byte = pos_q[LW-1 -: 8];
      RET_STR: tx_byte = proc_match_char;
      STATUS:  tx_byte = {VERSION, last_match_q, loaded_q, 2'b00};
      ACK:     tx_byte = 8'h01;
      default: tx_byte = 8'h00;
    endcase
    // uart busy rises one cycle late, so back-to-back pulses are blocked
    txd_start = (state_q == RET_POS || state_q == RET_STR ||
                 state_q == STATUS  || state_q == ACK ||
                 state_q == NACK) && !txd_busy && !start_prev_q;
    txd_data  = txd_start ? tx_byte : txd_data_q;
    proc_match_char_next = txd_start && (state_q == RET_STR);
    led_full  = 32'(state_q);
    led       = led_full[NUM_LEDS-1:0];
  end

  assign proc_start       = pstart_q;
  assign proc_num_bytes   = len_q;
  assign proc_data        = pdata_q;
  assign proc_data_valid  = pvalid_q;
  assign proc_target_hash = hash_q;
  assign cmd_error        = err_q;

endmodule

// File: tb/tb_cmd_parser_mp.sv
// Directed self-checking bench for cmd_parser_mp.
// Small uart_tx busy model and match-string pointer model included.
module tb_cmd_parser_mp;

  logic         clk = 0;
  logic         reset_n = 0;
  logic [7:0]   rxd_data = 0;
  logic         rxd_data_ready = 0;
  logic         txd_busy;
  logic         txd_start;
  logic [7:0]   txd_data;
  logic         proc_done = 0;
  logic         proc_match = 0;
  logic [15:0]  proc_byte_pos = 0;
  logic [7:0]   proc_match_char;
  logic         proc_start;
  logic [15:0]  proc_num_bytes;
  logic [7:0]   proc_data;
  logic         proc_data_valid;
  logic         proc_match_char_next;
  logic [127:0] proc_target_hash;
  logic         cmd_error;
  logic [7:0]   led;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] H1 = 128'h000102030405060708090A0B0C0D0E0F;

  cmd_parser_mp #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset_n(reset_n),
    .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
    .txd_busy(txd_busy), .txd_start(txd_start), .txd_data(txd_data),
    .proc_done(proc_done), .proc_match(proc_match),
    .proc_byte_pos(proc_byte_pos), .proc_match_char(proc_match_char),
    .proc_start(proc_start), .proc_num_bytes(proc_num_bytes),
    .proc_data(proc_data), .proc_data_valid(proc_data_valid),
    .proc_match_char_next(proc_match_char_next),
    .proc_target_hash(proc_target_hash), .cmd_error(cmd_error), .led(led)
  );

  always #5 clk = ~clk;

  int busy_cnt = 0;
  int mc_idx = 0;
  always @(posedge clk) begin
    if (txd_start) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (proc_match_char_next) mc_idx <= mc_idx + 1;
  end
  assign txd_busy = (busy_cnt != 0);
  assign proc_match_char = 8'h41 + 8'(mc_idx);

  logic [7:0]  tx_q[$];
  logic [7:0]  pv_q[$];
  int          ps_cnt = 0, err_cnt = 0, mcn_cnt = 0;
  int          hs_viol = 0, mis = 0, stab = 0;
  logic [15:0] ps_num = 0;
  logic        prev_st = 0, have_tx = 0;
  logic [7:0]  last_tx = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      have_tx = 0;
      prev_st = 0;
    end else begin
      if (txd_start) begin
        tx_q.push_back(txd_data);
        if (txd_busy || prev_st) hs_viol++;
        last_tx = txd_data;
        have_tx = 1;
      end else if (have_tx && txd_data !== last_tx) begin
        stab++;
      end
      if (proc_match_char_next) begin
        mcn_cnt++;
        if (!txd_start) mis++;
      end
      if (proc_start) begin
        ps_cnt++;
        ps_num = proc_num_bytes;
      end
      if (proc_data_valid) pv_q.push_back(proc_data);
      if (cmd_error) err_cnt++;
      prev_st = txd_start;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rxd_data = b;
    rxd_data_ready = 1;
    @(posedge clk); #1;
    rxd_data_ready = 0;
  endtask

  task automatic wait_tx(input int n, input string nm);
    int k = 0;
    while (tx_q.size() < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (tx_q.size() < n) begin
      errors++;
      $display("FAIL %s tx wait: got %0d bytes, need %0d", nm, tx_q.size(), n);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (txd_start !== 0 || txd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx got start=%b data=%h want 0 00", txd_start, txd_data);
    end
    checks++;
    if (proc_target_hash !== '0 || proc_num_bytes !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs got hash=%h len=%h want 0", proc_target_hash, proc_num_bytes);
    end
    checks++;
    if (led !== 8'h00 || cmd_error !== 0 || proc_start !== 0 ||
        proc_data_valid !== 0 || proc_match_char_next !== 0 || proc_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got led=%h err=%b ps=%b pv=%b want all 0",
               led, cmd_error, proc_start, proc_data_valid);
    end
    reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_unknown_status();
    int tb = tx_q.size();
    int eb = err_cnt;
    send_byte(8'h7F);
    wait_tx(tb + 1, "unknown");
    checks++;
    if (err_cnt - eb !== 1) begin
      errors++;
      $display("FAIL unknown_err got %0d pulses want 1", err_cnt - eb);
    end
    checks++;
    if (tx_q[tb] !== 8'h00) begin
      errors++;
      $display("FAIL unknown_nack got %h want 00", tx_q[tb]);
    end
    send_byte(8'h04);
    wait_tx(tb + 2, "status0");
    checks++;
    if (tx_q[tb+1] !== 8'h20) begin
      errors++;
      $display("FAIL status_empty got %h want 20", tx_q[tb+1]);
    end
  endtask

  task automatic test_set();
    int tb = tx_q.size();
    send_byte(8'h01);
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    checks++;
    if (proc_target_hash !== '0) begin
      errors++;
      $display("FAIL set_partial got %h want 0", proc_target_hash);
    end
    send_byte(8'h0F);
    checks++;
    if (txd_start !== 1 || txd_data !== 8'h01) begin
      errors++;
      $display("FAIL set_ack_latency got start=%b data=%h want 1 01", txd_start, txd_data);
    end
    wait_tx(tb + 1, "set");
    checks++;
    if (proc_target_hash !== H1) begin
      errors++;
      $display("FAIL set_hash got %h want %h", proc_target_hash, H1);
    end
    checks++;
    if (tx_q.size() !== tb + 1 || tx_q[tb] !== 8'h01) begin
      errors++;
      $display("FAIL set_tx got n=%0d b=%h want n=1 b=01", tx_q.size() - tb, tx_q[tb]);
    end
  endtask

  task automatic test_proc();
    int tb = tx_q.size();
    int pb = pv_q.size();
    int sb = ps_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h04);
    proc_done = 1;
    proc_match = 1;
    @(posedge clk); #1;
    proc_done = 0;
    proc_match = 0;
    wait_tx(tb + 1, "proc");
    checks++;
    if (ps_cnt - sb !== 1 || ps_num !== 16'd3) begin
      errors++;
      $display("FAIL proc_start got %0d pulses len=%0d want 1 len=3", ps_cnt - sb, ps_num);
    end
    checks++;
    if (pv_q.size() - pb !== 3) begin
      errors++;
      $display("FAIL proc_valid_cnt got %0d want 3", pv_q.size() - pb);
    end else begin
      checks++;
      if (pv_q[pb] !== 8'h61 || pv_q[pb+1] !== 8'h62 || pv_q[pb+2] !== 8'h63) begin
        errors++;
        $display("FAIL proc_data got %h %h %h want 61 62 63",
                 pv_q[pb], pv_q[pb+1], pv_q[pb+2]);
      end
    end
    checks++;
    if (tx_q.size() !== tb + 1 || tx_q[tb] !== 8'h01) begin
      errors++;
      $display("FAIL proc_ack got n=%0d b=%h want n=1 b=01", tx_q.size() - tb, tx_q[tb]);
    end
  endtask

  task automatic test_status(input logic [7:0] exp, input string nm);
    int tb = tx_q.size();
    send_byte(8'h04);
    wait_tx(tb + 1, nm);
    checks++;
    if (tx_q[tb] !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, tx_q[tb], exp);
    end
  endtask

  task automatic test_proc_zero();
    int tb = tx_q.size();
    int pb = pv_q.size();
    int sb = ps_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    wait_tx(tb + 1, "proc_zero");
    checks++;
    if (tx_q[tb] !== 8'h00 || ps_cnt !== sb || pv_q.size() !== pb) begin
      errors++;
      $display("FAIL proc_zero got tx=%h ps=%0d pv=%0d want 00 0 0",
               tx_q[tb], ps_cnt - sb, pv_q.size() - pb);
    end
  endtask

  task automatic test_proc_cmd_data();
    int tb = tx_q.size();
    int pb = pv_q.size();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h03);
    @(posedge clk); #1;
    proc_done = 1;
    @(posedge clk); #1;
    proc_done = 0;
    wait_tx(tb + 1, "proc_cmd");
    checks++;
    if (pv_q.size() - pb !== 2 || pv_q[pb] !== 8'h01 || pv_q[pb+1] !== 8'h03) begin
      errors++;
      $display("FAIL proc_cmd_data got n=%0d want 2 bytes 01 03", pv_q.size() - pb);
    end
    checks++;
    if (tx_q[tb] !== 8'h00) begin
      errors++;
      $display("FAIL proc_nomatch got %h want 00", tx_q[tb]);
    end
  endtask

  task automatic test_ret();
    int tb = tx_q.size();
    int mb = mcn_cnt;
    int bad = 0;
    proc_byte_pos = 16'h1234;
    send_byte(8'h03);
    proc_byte_pos = 16'hFFFF;
    wait_tx(tb + 22, "ret");
    checks++;
    if (tx_q[tb] !== 8'h12 || tx_q[tb+1] !== 8'h34) begin
      errors++;
      $display("FAIL ret_pos got %h %h want 12 34", tx_q[tb], tx_q[tb+1]);
    end
    for (int i = 0; i < 20; i++)
      if (tx_q[tb+2+i] !== 8'h41 + 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ret_str got %0d wrong chars want 0", bad);
    end
    checks++;
    if (mcn_cnt - mb !== 20 || mis !== 0 || tx_q.size() !== tb + 22) begin
      errors++;
      $display("FAIL ret_next got next=%0d mis=%0d n=%0d want 20 0 22",
               mcn_cnt - mb, mis, tx_q.size() - tb);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int tb = tx_q.size();
    int eb = err_cnt;
    int c = 0;
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'hAA);
    while (!txd_start && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 50 || txd_data !== 8'h00) begin
      errors++;
      $display("FAIL timeout_nack got cycles=%0d data=%h want 50 00", c, txd_data);
    end
    wait_tx(tb + 1, "timeout");
    checks++;
    if (err_cnt - eb !== 1 || proc_target_hash !== H1) begin
      errors++;
      $display("FAIL timeout_state got err=%0d hash=%h want 1 %h",
               err_cnt - eb, proc_target_hash, H1);
    end
  endtask
`endif

  task automatic test_reset_mid();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_n = 0;
    #1;
    checks++;
    if (proc_target_hash !== '0 || led !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got hash=%h led=%h want 0 00", proc_target_hash, led);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unknown_status();
    test_set();
    test_proc();
    test_status(8'h2C, "status_match");
    test_proc_zero();
    test_proc_cmd_data();
    test_status(8'h24, "status_nomatch");
    test_ret();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks++;
    if (hs_viol !== 0 || stab !== 0) begin
      errors++;
      $display("FAIL tx_handshake got viol=%0d unstable=%0d want 0 0", hs_viol, stab);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
